// File: rtl/pwm_multi.sv
// -----------------------------------------------------------------------------
// pwm_multi
//   Multi-channel PWM generator. All channels share one prescaler and one
//   period counter. Each channel owns a double-buffered duty register: writes
//   land in a shadow register and are copied into the active register only at
//   a period boundary, so a running waveform never glitches mid-period. The
//   period top value is shadowed the same way. Edge-aligned (sawtooth) and
//   center-aligned (triangle) counting are both supported.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   ena          global enable; low holds the counters at zero, forces the
//                outputs low and loads shadow duty/top straight into the
//                active registers every cycle
//   ch_ena       per-channel output enable
//   center       0 = edge-aligned, 1 = center-aligned
//   prescale     counter advances once every prescale+1 clocks
//   top          period top value, applied at the next period boundary
//   wr_en        duty write strobe
//   wr_ch        channel addressed by the write (out-of-range is ignored)
//   wr_duty      duty value written into the addressed shadow register
//   out          registered PWM outputs, one clock behind the counter
//   period_done  one-clock pulse in the cycle after each period boundary
// -----------------------------------------------------------------------------
module pwm_multi #(
   parameter  int N        = 8,
   parameter  int CHANNELS = 4,
   parameter  int PRESC_W  = 16,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                ena,
   input  logic [CHANNELS-1:0] ch_ena,
   input  logic                center,
   input  logic [PRESC_W-1:0]  prescale,
   input  logic [N-1:0]        top,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_ch,
   input  logic [N-1:0]        wr_duty,
   output logic [CHANNELS-1:0] out,
   output logic                period_done
);

   // Count direction of the center-aligned triangle.
   localparam logic [0:0] DIR_UP   = 1'b0;
   localparam logic [0:0] DIR_DOWN = 1'b1;

   localparam logic [N-1:0] FULL = {N{1'b1}};

   logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
   logic [N-1:0]        cnt_q, cnt_d;
   logic [0:0]          dir_q, dir_d;
   logic [N-1:0]        shadow_q   [CHANNELS];
   logic [N-1:0]        shadow_d   [CHANNELS];
   logic [N-1:0]        duty_act_q [CHANNELS];
   logic [N-1:0]        duty_act_d [CHANNELS];
   logic [N-1:0]        top_act_q, top_act_d;
   logic [CHANNELS-1:0] out_q, out_d;
   logic                period_done_q, period_done_d;

   logic                tick;
   logic                boundary;
   logic [CHANNELS-1:0] hi;

   // ---------------------------------------------------------------------------
   // Prescaler and period counter
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      pcnt_d   = pcnt_q;
      cnt_d    = cnt_q;
      dir_d    = dir_q;
      boundary = 1'b0;
      tick     = (pcnt_q == prescale);

      if (!ena) begin
         pcnt_d = '0;
         cnt_d  = '0;
         dir_d  = DIR_UP;
      end else if (!tick) begin
         pcnt_d = pcnt_q + PRESC_W'(1);
      end else begin
         pcnt_d = '0;
         if (!center) begin
            // Sawtooth. Forcing dir up here also handles leaving center mode
            // mid-period: counting simply resumes upward from cnt.
            dir_d = DIR_UP;
            if (cnt_q >= top_act_q) begin
               cnt_d    = '0;
               boundary = 1'b1;
            end else begin
               cnt_d = cnt_q + N'(1);
            end
         end else if ((dir_q == DIR_UP) && (cnt_q < top_act_q)) begin
            cnt_d = cnt_q + N'(1);
         end else if (cnt_q <= N'(1)) begin
            // Reaching zero on the way down closes the period. cnt==0 here
            // only happens with top_act==0, which then bounds every tick.
            cnt_d    = '0;
            dir_d    = DIR_UP;
            boundary = 1'b1;
         end else begin
            // Either already descending or just turned around at top_act.
            cnt_d = cnt_q - N'(1);
            dir_d = DIR_DOWN;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Shadow and active duty / top registers
   // ---------------------------------------------------------------------------
   always_comb begin
      shadow_d = shadow_q;
      if (wr_en && (32'(wr_ch) < CHANNELS)) begin
         shadow_d[wr_ch] = wr_duty;
      end

      // The active copy takes shadow_q, the value from before this edge, so a
      // write that lands on the boundary edge waits for the following period.
      duty_act_d = duty_act_q;
      top_act_d  = top_act_q;
      if (!ena || boundary) begin
         duty_act_d = shadow_q;
         top_act_d  = top;
      end
   end

   // ---------------------------------------------------------------------------
   // Output compare
   // ---------------------------------------------------------------------------
   always_comb begin
      hi = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (duty_act_q[i] == '0) begin
            hi[i] = 1'b0;
         end else if (duty_act_q[i] == FULL) begin
            // Needed explicitly: with top_act at full scale cnt reaches FULL
            // and the plain compare would drop low for one tick.
            hi[i] = 1'b1;
         end else begin
            hi[i] = (cnt_q < duty_act_q[i]);
         end
      end
      out_d         = {CHANNELS{ena}} & ch_ena & hi;
      period_done_d = boundary;
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         pcnt_q        <= '0;
         cnt_q         <= '0;
         dir_q         <= DIR_UP;
         top_act_q     <= FULL;
         out_q         <= '0;
         period_done_q <= 1'b0;
         // NOTE: the per-channel duty arrays are small flop banks, not RAM,
         // and their reset value is observable, so they are cleared here.
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i]   <= '0;
            duty_act_q[i] <= '0;
         end
      end else begin
         pcnt_q        <= pcnt_d;
         cnt_q         <= cnt_d;
         dir_q         <= dir_d;
         top_act_q     <= top_act_d;
         out_q         <= out_d;
         period_done_q <= period_done_d;
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i]   <= shadow_d[i];
            duty_act_q[i] <= duty_act_d[i];
         end
      end
   end

   assign out         = out_q;
   assign period_done = period_done_q;

endmodule

// File: tb/tb_pwm_multi.sv
// -----------------------------------------------------------------------------
// tb_pwm_multi
//   Directed bench for pwm_multi (N=8, CHANNELS=4, PRESC_W=16). The stimulus
//   process drives inputs just after each rising edge and pushes the expected
//   {period_done, out} for that cycle into a scoreboard queue; an independent
//   monitor pops one entry per falling edge and compares it with the DUT.
//   Expected waveforms are written in closed form from the cycle index k
//   counted from the first enabled edge.
// -----------------------------------------------------------------------------
module tb_pwm_multi;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [3:0] ch_ena;
   logic       center;
   logic [15:0] prescale;
   logic [7:0] top;
   logic       wr_en;
   logic [1:0] wr_ch;
   logic [7:0] wr_duty;
   logic [3:0] out_w;
   logic       pd_w;

   typedef struct {
      string      name;
      logic [3:0] out;
      logic       pd;
   } exp_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] cur [4];                              // duty each channel should show now
   int         cseq [8] = '{0, 1, 2, 3, 4, 3, 2, 1}; // center count for top=4

   always #5 clk = ~clk;

   pwm_multi #(
      .N        (8),
      .CHANNELS (4),
      .PRESC_W  (16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .ch_ena      (ch_ena),
      .center      (center),
      .prescale    (prescale),
      .top         (top),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_duty     (wr_duty),
      .out         (out_w),
      .period_done (pd_w)
   );

   task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: {period_done,out} got %b required %b at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: one comparison per scoreboard entry, sampled mid-cycle.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.name, {pd_w, out_w}, {e.pd, e.out});
      end
   end

   function automatic logic hi(input logic [7:0] d, input int c);
      if (d == 8'h00) return 1'b0;
      if (d == 8'hFF) return 1'b1;
      return (c < int'(d));
   endfunction

   function automatic logic [3:0] exp_out(input int c);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ch_ena[i] & hi(cur[i], c);
      return r;
   endfunction

   task automatic push(input string name, input logic [3:0] o, input logic p);
      exp_t e;
      e.name = name;
      e.out  = o;
      e.pd   = p;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_duty(input logic [1:0] ch, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_ch   = ch;
      wr_duty = d;
      step();
      wr_en   = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst      = 1'b1;
      ena      = 1'b1;
      ch_ena   = 4'b1111;
      center   = 1'b0;
      prescale = 16'd0;
      top      = 8'hFF;
      wr_en    = 1'b1;
      wr_ch    = 2'd0;
      wr_duty  = 8'hFF;
      for (int i = 0; i < 4; i++) cur[i] = 8'h00;

      // Reset wins over a simultaneous write and enable.
      repeat (3) begin
         step();
         push("reset", 4'b0000, 1'b0);
      end
      rst   = 1'b0;
      wr_en = 1'b0;
      // All duty zero: outputs stay low for three 256-clock periods.
      for (int k = 0; k < 768; k++) begin
         step();
         push("zero_duty", 4'b0000, (k % 256) == 255);
      end

      // Edge mode, top=9, prescale=0, loaded while disabled.
      ena    = 1'b0;
      top    = 8'd9;
      ch_ena = 4'b1011;
      write_duty(2'd0, 8'd3);
      write_duty(2'd1, 8'd2);
      write_duty(2'd2, 8'hFF);
      write_duty(2'd3, 8'd12);
      cur = '{8'd3, 8'd2, 8'hFF, 8'd12};
      repeat (2) step();
      ena = 1'b1;
      for (int k = 0; k < 80; k++) begin
         step();
         if (k == 30) cur[1] = 8'd5;   // mid-period write applied at next period
         if (k == 50) cur[1] = 8'd7;   // boundary-coincident write, one period late
         if (k == 60) begin
            cur[0] = 8'h00;
            cur[3] = 8'hFF;
         end
         push("edge", exp_out(k % 10), (k % 10) == 9);
         wr_en = 1'b0;
         if (k == 23) begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 8'd5;  end
         if (k == 38) begin wr_en = 1'b1; wr_ch = 2'd1; wr_duty = 8'd7;  end
         if (k == 52) begin wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 8'h00; end
         if (k == 53) begin wr_en = 1'b1; wr_ch = 2'd3; wr_duty = 8'hFF; end
      end
      wr_en = 1'b0;
      ena   = 1'b0;
      step();
      push("ena_drop_edge", 4'b0000, 1'b0);

      // Center mode, top=4: 0,1,2,3,4,3,2,1 with duty 2 high on 3 of 8 ticks.
      center = 1'b1;
      top    = 8'd4;
      write_duty(2'd0, 8'd2);
      write_duty(2'd1, 8'h00);
      write_duty(2'd3, 8'hFF);
      cur = '{8'd2, 8'h00, 8'hFF, 8'hFF};
      repeat (2) step();
      ena = 1'b1;
      for (int k = 0; k < 24; k++) begin
         step();
         push("center", exp_out(cseq[k % 8]), (k % 8) == 7);
      end

      // Prescale=3: counter advances every 4 clocks.
      ena      = 1'b0;
      center   = 1'b0;
      prescale = 16'd3;
      top      = 8'd9;
      write_duty(2'd0, 8'd3);
      cur[0] = 8'd3;
      repeat (2) step();
      ena = 1'b1;
      for (int k = 0; k < 50; k++) begin
         step();
         push("prescale", exp_out((k / 4) % 10), (k % 40) == 39);
      end
      ena = 1'b0;
      step();
      push("ena_drop_presc", 4'b0000, 1'b0);

      // New shadow duty is active straight away on re-enable, counter restarts.
      write_duty(2'd0, 8'd6);
      cur[0] = 8'd6;
      repeat (2) step();
      ena = 1'b1;
      for (int k = 0; k < 30; k++) begin
         step();
         push("reenable", exp_out((k / 4) % 10), (k % 40) == 39);
      end

      // Reset mid-period: everything back to reset values on the next clock.
      rst = 1'b1;
      step();
      push("rst_mid", 4'b0000, 1'b0);
      rst      = 1'b0;
      prescale = 16'd0;
      ch_ena   = 4'b1111;
      for (int k = 0; k < 40; k++) begin
         step();
         push("post_reset", 4'b0000, 1'b0);
      end

      step();
      step();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
